dg0045_ram_ctrl: RTL
====================

DG0045_RAM_CTRL -- requirements
Module: dg0045_ram_ctrl

Interface
REQ-001 SHALL have port RAM_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RAM_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-004 SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-005 SHALL have port cmd_op, input, 2 bits: 00 READ, 01 WRITE, 10 ADD, 11 CLR.
REQ-006 SHALL have port cmd_addr, input, 6 bits: target nibble address.
REQ-007 SHALL have port cmd_data, input, 4 bits: write data or addend.
REQ-008 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port rsp_data, output, 4 bits: result nibble.
REQ-010 SHALL have port rsp_carry, output, 1 bit: ADD carry-out.
REQ-011 SHALL have port init_done, output, 1 bit: post-reset RAM clear is complete.
REQ-012 SHALL have port ram_addr, output, 6 bits: drives the 64x4 RAM address.
REQ-013 SHALL have port ram_din, output, 4 bits: drives the RAM write data.
REQ-014 SHALL have port ram_dout, input, 4 bits: RAM combinational read data for ram_addr.

Function
REQ-015 SHALL assume nothing beyond the RAM contract: the RAM writes ram_din into ram_addr on every RAM_clk rising edge, and ram_dout is combinational.
REQ-016 SHALL therefore drive ram_din = ram_dout in every cycle where no modification is intended, so that the addressed location is rewritten unchanged.
REQ-017 SHALL implement states INIT, IDLE, EXEC and SWEEP.
REQ-018 INIT SHALL drive a 6-bit counter onto ram_addr with ram_din=0, increment the counter each cycle from 0 to 63, then enter IDLE and set init_done=1 (64 cycles).
REQ-019 IDLE SHALL set cmd_ready=1; cmd_ready SHALL be 0 in all other states.
REQ-020 In IDLE, ram_addr SHALL hold the last addressed location with ram_din=ram_dout.
REQ-021 Handshake: when cmd_valid=1 and cmd_ready=1 at an edge, the block SHALL register op, addr and data, then enter EXEC (op READ, WRITE or ADD) or SWEEP (op CLR).
REQ-022 EXEC SHALL last exactly one cycle with ram_addr set to the registered address.
REQ-023 EXEC READ: ram_din=ram_dout; rsp_data=ram_dout; rsp_carry=0.
REQ-024 EXEC WRITE: ram_din=registered data; rsp_data=registered data; rsp_carry=0.
REQ-025 EXEC ADD: sum = ram_dout + data as 5-bit; ram_din=sum[3:0]; rsp_data=sum[3:0]; rsp_carry=sum[4]; results wrap modulo 16.
REQ-026 SWEEP SHALL write 0 to addresses 0..63 in order (64 cycles, cmd_addr ignored), with rsp_data=0 and rsp_carry=0.
REQ-027 rsp_valid, rsp_data and rsp_carry SHALL be registered, with rsp_valid high for exactly one cycle after the final EXEC or SWEEP edge; the block SHALL return to IDLE on that same edge.
REQ-028 Latency: accept at edge N gives rsp_valid high in cycle N+1..N+2 for EXEC ops, and in cycle N+64..N+65 for CLR; command throughput is at most one per 2 cycles.
REQ-029 rsp_data and rsp_carry SHALL hold their values until the next response.
REQ-030 cmd_valid SHALL be ignored outside IDLE; no command is queued.
REQ-031 ram_addr and ram_din SHALL be decoded from registered state; there is no combinational path from cmd_* to ram_*.

Reset
REQ-032 RAM_rst_n low SHALL immediately force state=INIT, counter=0, init_done=0, rsp_valid=0, rsp_data=0, rsp_carry=0 and cmd_ready=0.
REQ-033 While reset is held, the block SHALL drive ram_addr=0 and ram_din=0.
REQ-034 Reset mid-EXEC or mid-SWEEP SHALL abandon the operation with no response, and INIT SHALL restart from address 0.
REQ-035 After release, init_done SHALL rise after 64 edges.

Verification
REQ-036 Release reset -> 64 cycles of ram_addr 0..63 with ram_din 0, then init_done=1 and cmd_ready=1; all RAM locations read 0.
REQ-037 WRITE addr 5 data 0xA, then READ addr 5 -> rsp_data=0xA and rsp_carry=0; addr 4 and addr 6 still read 0.
REQ-038 Location 9=0xE: ADD 0x3 -> rsp_data=0x1, rsp_carry=1, location 9=0x1; ADD 0x0 -> rsp_data=0x1, rsp_carry=0.
REQ-039 Hold cmd_valid continuously with back-to-back commands -> cmd_ready alternates, each command executes exactly once, and 5 idle cycles leave all locations unchanged.
REQ-040 Fill addr 63=0xF and 0=0x7, then CLR -> rsp_valid after 64 cycles and all 64 locations read 0; assert reset at sweep cycle 20 -> no rsp_valid, and INIT restarts at address 0.

Source files
------------

// File: rtl/dg0045_ram_ctrl.sv
// -----------------------------------------------------------------------------
// dg0045_ram_ctrl
// Command controller for an external 64x4 RAM. The RAM writes ram_din into
// ram_addr on every clock edge, so the controller drives ram_din = ram_dout
// whenever a location must stay unchanged.
//
// After reset the controller clears the whole RAM (INIT). It then accepts one
// command at a time in IDLE:
//   READ  - return the addressed nibble
//   WRITE - store cmd_data, echo it back
//   ADD   - add cmd_data modulo 16, return the sum and its carry-out
//   CLR   - zero all 64 locations (SWEEP), then respond with 0
// Each command gets a one-cycle rsp_valid pulse. rsp_data and rsp_carry hold
// their values until the next response.
//
// Ports
//   RAM_clk, RAM_rst_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_op, cmd_addr, cmd_data    : command opcode, nibble address, operand
//   rsp_valid/rsp_data/rsp_carry  : registered response
//   init_done                     : post-reset RAM clear has finished
//   ram_addr, ram_din, ram_dout   : RAM address, write data, read data
// -----------------------------------------------------------------------------
module dg0045_ram_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 6
) (
    input  logic              RAM_clk,
    input  logic              RAM_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              init_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_SWEEP = 2'd3
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    // Nibble add that keeps the carry in the extra top bit.
    function automatic logic [DATA_W:0] add_carry(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                init_done_q, init_done_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W:0]     sum;

    assign sum = add_carry(ram_dout, data_q);

    // addr_q doubles as the INIT/SWEEP counter and the registered command
    // address; in IDLE it simply keeps the last location touched.
    assign ram_addr  = addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign init_done = init_done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        cmd_ready   = 1'b0;
        ram_din     = ram_dout;

        case (state_q)
            ST_INIT: begin
                ram_din = '0;
                if (addr_q == ADDR_LAST) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end

            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    if (cmd_op == OP_CLR) begin
                        state_d = ST_SWEEP;
                        addr_d  = '0;
                    end else begin
                        state_d = ST_EXEC;
                        addr_d  = cmd_addr;
                    end
                end
            end

            ST_EXEC: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_carry_d = 1'b0;
                case (op_q)
                    OP_WRITE: begin
                        ram_din    = data_q;
                        rsp_data_d = data_q;
                    end
                    OP_ADD: begin
                        ram_din     = sum[DATA_W-1:0];
                        rsp_data_d  = sum[DATA_W-1:0];
                        rsp_carry_d = sum[DATA_W];
                    end
                    default: begin
                        // READ (CLR never reaches EXEC): rewrite unchanged.
                        rsp_data_d = ram_dout;
                    end
                endcase
            end

            ST_SWEEP: begin
                ram_din = '0;
                if (addr_q == ADDR_LAST) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_carry_d = 1'b0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_INIT;
                ram_din = '0;
            end
        endcase
    end

    always_ff @(posedge RAM_clk or negedge RAM_rst_n) begin
        if (!RAM_rst_n) begin
            state_q     <= ST_INIT;
            addr_q      <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end

    // Command operand registers only matter once a command is accepted.
    always_ff @(posedge RAM_clk) begin
        op_q   <= op_d;
        data_q <= data_d;
    end

endmodule
